// File: rtl/serial_paralelo_rx.sv
// ============================================================================
// serial_paralelo_rx
//   Receive-side deserializer. It takes the 1-bit serial stream from the PHY
//   Tx (MSB first) and rebuilds 8-bit lane bytes. The byte boundary is found
//   by hunting for the COM symbol. After BC_COUNT consecutive aligned COM
//   bytes the lane is declared active. Non-COM bytes are forwarded only while
//   the lane is active.
//
// Parameters
//   COM_BYTE   alignment/idle symbol; it is never forwarded as data
//   BC_COUNT   number of consecutive aligned COM bytes needed to lock
//
// Ports
//   clk_8f     in   1  bit clock; one serial bit per rising edge
//   reset      in   1  asynchronous reset, active low
//   data_in    in   1  serial input bit, sampled on rising clk_8f
//   data_out   out  8  recovered byte (registered)
//   valid_out  out  1  data_out holds a non-COM byte received while active
//   active     out  1  lane aligned and locked (sticky until reset)
// ============================================================================
module serial_paralelo_rx #(
    parameter logic [7:0] COM_BYTE = 8'hBC,
    parameter int         BC_COUNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    // bc_cnt must be able to hold BC_COUNT itself.
    localparam int            BCW    = (BC_COUNT < 1) ? 1 : $clog2(BC_COUNT + 1);
    localparam logic [BCW-1:0] BC_MAX = BCW'(BC_COUNT);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ALIGNED = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    state_t         state;
    // Only the 7 most recent bits are stored. The incoming bit completes the
    // candidate byte combinationally, so an eighth stored bit would never be
    // used.
    logic [6:0]     shift_reg;
    logic [2:0]     bit_cnt;
    logic [BCW-1:0] bc_cnt;

    logic [7:0]     cand;
    logic           is_com;
    logic           boundary;
    logic [BCW-1:0] bc_inc;
    logic           lock_now;

    // cand is the byte that ends with the bit sampled on this edge.
    assign cand     = {shift_reg, data_in};
    assign is_com   = (cand == COM_BYTE);
    assign boundary = (bit_cnt == 3'd7);

    // bc_cnt saturates at BC_COUNT and does not wrap.
    assign bc_inc   = (bc_cnt == BC_MAX) ? bc_cnt : bc_cnt + 1'b1;
    assign lock_now = (bc_inc == BC_MAX);

    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            state     <= HUNT;
            shift_reg <= '0;
            bit_cnt   <= '0;
            bc_cnt    <= '0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            shift_reg <= cand[6:0];
            bit_cnt   <= bit_cnt + 3'd1;

            case (state)
                // Slide one bit per edge until COM shows up. The match may
                // straddle arbitrary junk. Restarting bit_cnt here places the
                // next boundary exactly 8 edges later.
                HUNT: begin
                    if (is_com) begin
                        bit_cnt <= 3'd0;
                        bc_cnt  <= BCW'(1);
                        if (BC_COUNT <= 1) begin
                            state  <= ACTIVE;
                            active <= 1'b1;
                        end else begin
                            state  <= ALIGNED;
                        end
                    end
                end

                // Count aligned COM bytes. Any non-COM byte on a boundary was
                // a false lock, so hunting starts again.
                ALIGNED: begin
                    if (boundary) begin
                        if (is_com) begin
                            bc_cnt <= bc_inc;
                            if (lock_now) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            state  <= HUNT;
                            bc_cnt <= '0;
                        end
                    end
                end

                // Locked until reset. COM drops valid but keeps the last byte.
                // Anything else is forwarded as-is, even if the alignment has
                // since slipped.
                ACTIVE: begin
                    if (boundary) begin
                        if (is_com) begin
                            valid_out <= 1'b0;
                        end else begin
                            data_out  <= cand;
                            valid_out <= 1'b1;
                        end
                    end
                end

                default: begin
                    state  <= HUNT;
                    bc_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// ============================================================================
// tb_serial_paralelo_rx
//   Scoreboard bench for serial_paralelo_rx. Each byte sent pushes the
//   output state expected once its LSB has been sampled. A negedge monitor
//   pops that expectation in the cycle it becomes due. In every other cycle
//   it checks that the outputs still hold the last expected state, so level
//   validity and premature lock are both caught.
// ============================================================================
module tb_serial_paralelo_rx;

    logic       clk_8f = 1'b0;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    serial_paralelo_rx #(.COM_BYTE(8'hBC), .BC_COUNT(4)) dut (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    always #5 clk_8f = ~clk_8f;

    typedef struct {
        int         due;
        logic       v;
        logic [7:0] d;
        logic       a;
    } exp_t;

    exp_t sb[$];
    exp_t cur = '{0, 1'b0, 8'h00, 1'b0};
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk_8f) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: checks the due expectation, or checks that the outputs are held.
    always @(negedge clk_8f) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            cur   = mon_e;
            chk("byte_valid",  {31'd0, valid_out}, {31'd0, cur.v});
            chk("byte_data",   {24'd0, data_out},  {24'd0, cur.d});
            chk("byte_active", {31'd0, active},    {31'd0, cur.a});
        end else begin
            chk("hold_valid",  {31'd0, valid_out}, {31'd0, cur.v});
            chk("hold_data",   {24'd0, data_out},  {24'd0, cur.d});
            chk("hold_active", {31'd0, active},    {31'd0, cur.a});
        end
    end

    // Send b MSB first, then push the state expected after its LSB edge.
    task automatic send_byte(input logic [7:0] b, input logic v,
                             input logic [7:0] d, input logic a);
        exp_t e;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk_8f);
            data_in = b[i];
        end
        e.due = cyc + 1;
        e.v   = v;
        e.d   = d;
        e.a   = a;
        sb.push_back(e);
    endtask

    // Send the low n bits of b, MSB first, with no expectation pushed.
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk_8f);
            data_in = b[i];
        end
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_8f);
            data_in = ~data_in;
            #1;
            chk("rst_data",   {24'd0, data_out},  32'h00);
            chk("rst_valid",  {31'd0, valid_out}, 32'h0);
            chk("rst_active", {31'd0, active},    32'h0);
        end
        @(negedge clk_8f);
        reset   = 1'b1;
        data_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        data_in = 1'b0;

        // 1: outputs stay at reset values while data toggles.
        hold_reset(5);

        // 2: junk, then 4x COM. Lock comes on the LSB of the 4th COM.
        send_bits(8'b010, 3);
        send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
        send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
        send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
        send_byte(8'hBC, 1'b0, 8'h00, 1'b1);

        // 3: data stream framed by COM.
        send_byte(8'hBC, 1'b0, 8'h00, 1'b1);
        send_byte(8'hEE, 1'b1, 8'hEE, 1'b1);
        send_byte(8'h01, 1'b1, 8'h01, 1'b1);
        send_byte(8'hFF, 1'b1, 8'hFF, 1'b1);
        send_byte(8'hBC, 1'b0, 8'hFF, 1'b1);

        // 6: asymmetric byte (its bit-reverse is BF).
        send_byte(8'hFD, 1'b1, 8'hFD, 1'b1);

        // 5: reset mid-byte while active. Outputs clear at once.
        send_bits(8'b101, 3);
        @(negedge clk_8f);
        reset = 1'b0;
        #1;
        chk("midrst_data",   {24'd0, data_out},  32'h00);
        chk("midrst_valid",  {31'd0, valid_out}, 32'h0);
        chk("midrst_active", {31'd0, active},    32'h0);
        cur = '{0, 1'b0, 8'h00, 1'b0};
        hold_reset(3);

        // 4: a broken preamble restarts the count. A full 4x COM is needed again.
        send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
        send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
        send_byte(8'h5A, 1'b0, 8'h00, 1'b0);
        send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
        send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
        send_byte(8'hBC, 1'b0, 8'h00, 1'b0);
        send_byte(8'hBC, 1'b0, 8'h00, 1'b1);
        send_byte(8'h3C, 1'b1, 8'h3C, 1'b1);
        send_byte(8'hBC, 1'b0, 8'h3C, 1'b1);

        repeat (3) @(negedge clk_8f);
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
